// File: rtl/mux_scan.sv
// Registered N-channel x WIDTH-bit multiplexer with manual select and a
// round-robin scan mode, presented on a valid/ready output.

module mux_scan_lane #(
  parameter int CH_BITS = 6
) (
  input  logic [(1<<CH_BITS)-1:0] bits,
  input  logic [CH_BITS-1:0]      ch,
  output logic                    q
);
  assign q = bits[ch];
endmodule

module mux_scan #(
  parameter int CH_BITS = 6,
  parameter int WIDTH   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [(1<<CH_BITS)*WIDTH-1:0]     in,
  input  logic                              en,
  input  logic                              mode,
  input  logic [CH_BITS-1:0]                sel,
  output logic [WIDTH-1:0]                  out,
  output logic [CH_BITS-1:0]                out_ch,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready
);
  localparam int N = 1 << CH_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [CH_BITS-1:0] ch;
    logic               last;
    logic               valid;
  } rsp_t;

  state_t             state, state_d;
  logic [CH_BITS-1:0] ptr, ptr_d, cap_ch;
  rsp_t               rsp_q, rsp_d;
  logic               load;

  // Bit-sliced mux: lane b picks bit b of the captured channel.
  logic [WIDTH-1:0][N-1:0] lane_bits;
  logic [WIDTH-1:0]        lane_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_ch
      assign lane_bits[b][k] = in[k*WIDTH + b];
    end
    mux_scan_lane #(.CH_BITS(CH_BITS)) u_lane (
      .bits (lane_bits[b]),
      .ch   (cap_ch),
      .q    (lane_q[b])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state: any state reachable from any other in one cycle
  always_comb begin
    state_d = S_IDLE;
    if (en) state_d = mode ? S_SCAN : S_MANUAL;
  end

  // Output / pointer logic
  always_comb begin
    load   = !rsp_q.valid || out_ready;
    cap_ch = (state == S_SCAN) ? ptr : sel;
    rsp_d  = rsp_q;
    ptr_d  = '0;
    if (load) begin
      case (state)
        S_MANUAL: rsp_d = '{data: lane_q, ch: sel, last: 1'b0, valid: 1'b1};
        S_SCAN:   rsp_d = '{data: lane_q, ch: ptr, last: (ptr == sel), valid: 1'b1};
        default: begin
          rsp_d.valid = 1'b0;
          rsp_d.last  = 1'b0;
        end
      endcase
    end
    // Pointer only moves on load so a stalled consumer never loses a channel;
    // ">=" wraps immediately if the limit was lowered under the pointer.
    if (state == S_SCAN) begin
      if (load) ptr_d = (ptr >= sel) ? '0 : ptr + 1'b1;
      else      ptr_d = ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
      ptr   <= '0;
    end else begin
      rsp_q <= rsp_d;
      ptr   <= ptr_d;
    end
  end

  assign out       = rsp_q.data;
  assign out_ch    = rsp_q.ch;
  assign out_last  = rsp_q.last;
  assign out_valid = rsp_q.valid;

endmodule

// File: tb/tb_mux_scan.sv
// Directed + random bench for mux_scan (CH_BITS=3, WIDTH=4) against a
// cycle-level reference built from the channel/sweep rules.

module tb_mux_scan;
  localparam int CB = 3;
  localparam int W  = 4;
  localparam int N  = 1 << CB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_v;
  logic            en, mode, out_ready;
  logic [CB-1:0]   sel;
  logic [W-1:0]    out;
  logic [CB-1:0]   out_ch;
  logic            out_last, out_valid;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state;   // 0 idle, 1 manual, 2 scan (registered from en/mode)
  int m_ptr, m_out, m_ch, m_last, m_valid;

  mux_scan #(.CH_BITS(CB), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_v),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .out       (out),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int chan(input int k);
    logic [N*W-1:0] v;
    v = in_v;
    return int'(v[k*W +: W]);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_out = 0; m_ch = 0; m_last = 0; m_valid = 0;
  endtask

  // What the upcoming rising edge does, from current inputs.
  task automatic model_edge();
    bit ld;
    if (!rst_n) begin model_reset(); return; end
    ld = (m_valid == 0) || out_ready;
    if (ld) begin
      if (m_state == 0) begin
        m_valid = 0; m_last = 0;
      end else if (m_state == 1) begin
        m_out = chan(int'(sel)); m_ch = int'(sel); m_last = 0; m_valid = 1;
      end else begin
        m_out = chan(m_ptr); m_ch = m_ptr; m_last = (m_ptr == int'(sel)); m_valid = 1;
      end
    end
    if (m_state != 2)  m_ptr = 0;
    else if (ld)       m_ptr = (m_ptr >= int'(sel)) ? 0 : m_ptr + 1;
    m_state = !en ? 0 : (mode ? 2 : 1);
  endtask

  task automatic check_model();
    chk("out",       int'(out),       m_out);
    chk("out_ch",    int'(out_ch),    m_ch);
    chk("out_last",  int'(out_last),  m_last);
    chk("out_valid", int'(out_valid), m_valid);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N; k++) in_v[k*W +: W] = W'(k + 8);
  endtask

  initial begin
    int exp_seq[6];
    int wrap_seq[5];
    int hold_out, hold_ch;
    bit found;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_v = '0;
    set_ramp();
    model_reset();
    #12;
    chk("rst_out", int'(out), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // MANUAL: 2-clock latency, then follow sel
    en = 1'b1; mode = 1'b0; sel = 3'd5;
    step();
    chk("man_lat_valid_lo", int'(out_valid), 0);
    step();
    chk("man_valid", int'(out_valid), 1);
    chk("man_out5", int'(out), 13);
    chk("man_ch5", int'(out_ch), 5);
    chk("man_last", int'(out_last), 0);
    sel = 3'd2;
    step();
    chk("man_out2", int'(out), 10);

    // SCAN limit 3 (first edge still captures in MANUAL)
    mode = 1'b1; sel = 3'd3;
    step();
    exp_seq = '{0, 1, 2, 3, 0, 1};
    foreach (exp_seq[i]) begin
      step();
      chk("scan_ch", int'(out_ch), exp_seq[i]);
      chk("scan_out", int'(out), exp_seq[i] + 8);
      chk("scan_last", int'(out_last), int'(exp_seq[i] == 3));
    end

    // SCAN limit 7, stall at ch4
    sel = 3'd7;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (out_ch == 3'd4) found = 1'b1;
    end
    chk("reach_ch4", int'(found), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out", int'(out), 12);
      chk("stall_ch", int'(out_ch), 4);
      chk("stall_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("resume_ch5", int'(out_ch), 5);

    // lower limit under the pointer: ch6, then wrap within 0..2
    sel = 3'd2;
    wrap_seq = '{6, 0, 1, 2, 0};
    foreach (wrap_seq[i]) begin
      step();
      chk("shrink_ch", int'(out_ch), wrap_seq[i]);
    end
    sel = 3'd0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sel0_ch", int'(out_ch), 0);
      chk("sel0_out", int'(out), 8);
      chk("sel0_last", int'(out_last), 1);
    end

    // drop enable mid-sweep
    sel = 3'd7;
    repeat (3) step();
    en = 1'b0;
    step();
    hold_out = int'(out); hold_ch = int'(out_ch);
    chk("dis_valid_still", int'(out_valid), 1);
    step();
    chk("dis_valid", int'(out_valid), 0);
    chk("dis_hold_out", int'(out), hold_out);
    chk("dis_hold_ch", int'(out_ch), hold_ch);
    en = 1'b1; mode = 1'b1;
    step();
    step();
    chk("reen_ch0", int'(out_ch), 0);
    chk("reen_valid", int'(out_valid), 1);

    // async reset between edges
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out", int'(out), 0);
    chk("arst_ch", int'(out_ch), 0);
    chk("arst_last", int'(out_last), 0);
    chk("arst_valid", int'(out_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("rel_lat_valid_lo", int'(out_valid), 0);
    step();
    chk("rel_valid", int'(out_valid), 1);
    chk("rel_ch0", int'(out_ch), 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) in_v[k*W +: W] = W'($urandom_range(0, 15));
      en        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 5) == 0) sel  = CB'($urandom_range(0, N-1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N-channel by WIDTH-bit multiplexer.
- Successor to the fixed 64:1 single-bit combinational mux.
- Two modes:
  - MANUAL: registered select of the channel given by sel.
  - SCAN: autonomous round-robin sweep of channels 0..sel.
- Output side uses a valid/ready handshake, so it can feed a serialiser or sampling logic in the data path.

Parameters:
- CH_BITS, 6, log2 of channel count; N = 2**CH_BITS channels.
- WIDTH, 1, data bits per channel.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  asynchronous, active-low reset.
- in  input  N*WIDTH  channel data; channel k is in[k*WIDTH +: WIDTH].
- en  input  1  block enable.
- mode  input  1  0 = MANUAL, 1 = SCAN.
- sel  input  CH_BITS  MANUAL: channel to select. SCAN: last channel of the sweep (limit).
- out  output  WIDTH  selected channel data, registered.
- out_ch  output  CH_BITS  index of the channel currently in out.
- out_last  output  1  SCAN only: high when out_ch equals the limit in force at capture.
- out_valid  output  1  out, out_ch and out_last are valid.
- out_ready  input  1  consumer accepts the output.

Behaviour:
- Reset (rst_n low, async assert): out=0, out_ch=0, out_last=0, out_valid=0, ptr=0, state=IDLE. Deassertion is taken synchronously.
- State register, updated every clk:
  - next = IDLE if !en
  - next = SCAN if en & mode
  - next = MANUAL otherwise.
  - Transitions are allowed between any two states in a single cycle.
- load = !out_valid | out_ready. The output register changes only on load cycles; otherwise out, out_ch, out_last and out_valid hold.
- IDLE:
  - On load: out_valid<=0. out and out_ch hold their last values; out_last<=0.
  - ptr<=0.
- MANUAL:
  - On load: out<=in[sel], out_ch<=sel, out_last<=0, out_valid<=1.
  - ptr<=0.
  - Values are sampled from in/sel at the load edge.
- SCAN:
  - On load: out<=in[ptr], out_ch<=ptr, out_last<=(ptr==sel), out_valid<=1.
  - ptr update: ptr<=(ptr>=sel) ? 0 : ptr+1.
  - Wrap to 0 occurs at the limit.
  - If sel is lowered below ptr mid-sweep, the current ptr is emitted, then ptr wraps to 0.
  - sel=0 gives continuous ch0 output with out_last=1 every word.
  - ptr advances only on load cycles, so backpressure stalls the sweep without skipping any channel.
- Latency:
  - en/mode change to first word on out is 2 clocks: 1 for the state register, 1 for the output register, assuming out_ready=1 or out_valid=0.
  - Steady state: 1 word per clock while out_ready=1.
- Handshake:
  - A word is transferred on a clock edge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, the word is stable.
  - out_valid never drops without a transfer, except on reset or a load cycle in IDLE.
- Mode switch SCAN to MANUAL and back: the sweep restarts at ch0, because ptr is cleared whenever state != SCAN.
- Reset mid-operation: all outputs clear immediately (async). The first word after release follows the 2-clock latency above.
- Indices are unsigned CH_BITS wide. Every sel value is a legal channel, so there is no out-of-range case.

Test Plan:
- CH_BITS=3, WIDTH=4, in channel k = k+8 (ch0=8 .. ch7=15), out_ready=1. en=1, mode=0, sel=5 -> out_valid rises 2 clocks after en; out=13, out_ch=5, out_last=0. Change sel to 2 -> out=10 the next clock.
- Same data, mode=1, sel=3, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,... with out=8,9,10,11,8. out_last=1 only when out_ch=3.
- SCAN with sel=7, out_ready low for 3 clocks while out_ch=4 -> out=12 and out_ch=4 held stable with out_valid=1. When out_ready rises, next words are ch5 then ch6, with no skip.
- SCAN with sel=7 at ptr=6, then sel changed to 2 -> ch6 emitted, then wrap to ch0,1,2,0. Also sel=0 -> constant ch0, out=8, out_last=1 every clock.
- en dropped mid-sweep with out_ready=1 -> out_valid=0 two clocks later; out and out_ch hold. Re-enable in SCAN -> sweep restarts at ch0.
- rst_n pulsed low mid-sweep, asynchronously and between clock edges -> out, out_ch, out_last and out_valid are 0 immediately. After release with en=1, mode=1, the first word is ch0 two clocks later.
